lsu_bus_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the single-cycle core's decode/ALU stage and a handshaked data-memory bus. It takes the controller's `mem_rd`/`mem_wr`/`mem_mode` and the ALU address, stalls the core while a bus transaction is in flight, and generates byte enables and write-lane replication. On loads it extracts the addressed byte or halfword and returns the sign- or zero-extended result for write-back (`wb_sel = 1`). Misaligned accesses and bus timeouts are detected and flagged without touching the bus.

---
 rtl/lsu_bus_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu_bus_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_sequencer
// Purpose  : Multi-cycle load/store sequencer between a single-cycle core and
//            a req/ack data-memory bus. It stalls the core while a bus
//            transaction is in flight and forms the byte enables and the
//            lane-replicated store data. On loads it extracts the addressed
//            byte or halfword and sign- or zero-extends it. Illegal or
//            misaligned requests and bus timeouts are flagged.
// Ports    : clk, rst (async, active-high)
//            i_mem_rd, i_mem_wr, i_mem_mode, i_ld_unsigned,
//            i_addr, i_wdata                          - core request
//            o_stall, o_rdata, o_misalign_err, o_bus_err - core response
//            o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
//            i_bus_ack, i_bus_rdata                   - memory bus
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [1:0]  i_mem_mode,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_misalign_err,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds the number of REQ cycles already spent; the abort
    // decision is taken in the last allowed cycle so bus_req stays high for
    // exactly TIMEOUT_CYCLES cycles.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_MODE_BYTE = 2'b00;
    localparam logic [1:0] c_MODE_HALF = 2'b01;
    localparam logic [1:0] c_MODE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [3:0]         r_bus_be;
    logic [31:0]        r_bus_wdata;
    logic [31:0]        r_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic [1:0]         r_lane;
    logic [1:0]         r_mode;
    logic               r_uns;

    logic        w_req;
    logic        w_illegal;
    logic        w_expire;
    logic        w_start;
    logic        w_stall;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_req     = i_mem_rd | i_mem_wr;
    assign w_illegal = (i_mem_mode == 2'b11)
                     | (i_mem_rd & i_mem_wr)
                     | ((i_mem_mode == c_MODE_HALF) & i_addr[0])
                     | ((i_mem_mode == c_MODE_WORD) & (i_addr[1:0] != 2'b00));
    assign w_expire  = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_mem_mode)
            c_MODE_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            c_MODE_HALF: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and core-facing handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_stall    = 1'b0;
        w_misalign = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        // Core commits with no memory effect; no stall.
                        w_misalign = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_start = 1'b1;
                        w_next  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (i_bus_ack || w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus fields, captured data, timeout counter and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_data      <= 32'd0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_lane      <= 2'd0;
            r_mode      <= 2'd0;
            r_uns       <= 1'b0;
        end else if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= i_mem_wr;
            r_bus_addr  <= {i_addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_lane      <= i_addr[1:0];
            r_mode      <= i_mem_mode;
            r_uns       <= i_ld_unsigned;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else if (r_state == S_REQ) begin
            // Ack has priority over a same-cycle expiry.
            if (i_bus_ack) begin
                r_data    <= i_bus_rdata;
                r_bus_req <= 1'b0;
            end else if (w_expire) begin
                r_data    <= 32'd0;
                r_err     <= 1'b1;
                r_bus_req <= 1'b0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the captured word
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = r_data[7:0];
        case (r_lane)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
    end

    assign w_half = r_lane[1] ? r_data[31:16] : r_data[15:0];

    always_comb begin
        w_rdata = 32'd0;
        if ((r_state == S_DONE) && !r_bus_we) begin
            case (r_mode)
                c_MODE_BYTE: w_rdata = {{24{~r_uns & w_byte[7]}}, w_byte};
                c_MODE_HALF: w_rdata = {{16{~r_uns & w_half[15]}}, w_half};
                default:     w_rdata = r_data;
            endcase
        end
    end

    assign o_stall        = w_stall;
    assign o_misalign_err = w_misalign;
    assign o_rdata        = w_rdata;
    assign o_bus_err      = (r_state == S_DONE) & r_err;
    assign o_bus_req      = r_bus_req;
    assign o_bus_we       = r_bus_we;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_be       = r_bus_be;
    assign o_bus_wdata    = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_sequencer
// Purpose  : Self-checking bench for lsu_bus_sequencer. Two instances share
//            the stimulus: one with the default timeout, one with a timeout
//            of 4 cycles; r_sel routes requests/acks to one of them and
//            selects which outputs are observed. Expected transaction results
//            are queued when a request is driven and checked in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_sequencer;

    localparam int c_BOUND = 400;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          req_cycles;
    } exp_t;

    exp_t sb[$];

    logic        clk;
    logic        rst;
    logic        r_sel;
    logic        r_rd, r_wr, r_uns, r_ack;
    logic [1:0]  r_mode;
    logic [31:0] r_addr, r_wd, r_brd;

    int n_checks;
    int n_fail;

    logic w_a_rd, w_a_wr, w_a_ack, w_b_rd, w_b_wr, w_b_ack;
    assign w_a_rd  = r_rd  & ~r_sel;
    assign w_a_wr  = r_wr  & ~r_sel;
    assign w_a_ack = r_ack & ~r_sel;
    assign w_b_rd  = r_rd  &  r_sel;
    assign w_b_wr  = r_wr  &  r_sel;
    assign w_b_ack = r_ack &  r_sel;

    logic        a_stall, a_mis, a_berr, a_req, a_we;
    logic [31:0] a_rdata, a_baddr, a_bwdata;
    logic [3:0]  a_be;
    logic        b_stall, b_mis, b_berr, b_req, b_we;
    logic [31:0] b_rdata, b_baddr, b_bwdata;
    logic [3:0]  b_be;

    lsu_bus_sequencer dut (
        .clk(clk), .rst(rst),
        .i_mem_rd(w_a_rd), .i_mem_wr(w_a_wr), .i_mem_mode(r_mode),
        .i_ld_unsigned(r_uns), .i_addr(r_addr), .i_wdata(r_wd),
        .o_stall(a_stall), .o_rdata(a_rdata), .o_misalign_err(a_mis),
        .o_bus_err(a_berr), .o_bus_req(a_req), .o_bus_we(a_we),
        .o_bus_addr(a_baddr), .o_bus_be(a_be), .o_bus_wdata(a_bwdata),
        .i_bus_ack(w_a_ack), .i_bus_rdata(r_brd)
    );

    lsu_bus_sequencer #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .i_mem_rd(w_b_rd), .i_mem_wr(w_b_wr), .i_mem_mode(r_mode),
        .i_ld_unsigned(r_uns), .i_addr(r_addr), .i_wdata(r_wd),
        .o_stall(b_stall), .o_rdata(b_rdata), .o_misalign_err(b_mis),
        .o_bus_err(b_berr), .o_bus_req(b_req), .o_bus_we(b_we),
        .o_bus_addr(b_baddr), .o_bus_be(b_be), .o_bus_wdata(b_bwdata),
        .i_bus_ack(w_b_ack), .i_bus_rdata(r_brd)
    );

    logic        o_stall, o_mis, o_berr, o_req, o_we;
    logic [31:0] o_rdata, o_baddr, o_bwdata;
    logic [3:0]  o_be;
    assign o_stall  = r_sel ? b_stall  : a_stall;
    assign o_mis    = r_sel ? b_mis    : a_mis;
    assign o_berr   = r_sel ? b_berr   : a_berr;
    assign o_req    = r_sel ? b_req    : a_req;
    assign o_we     = r_sel ? b_we     : a_we;
    assign o_rdata  = r_sel ? b_rdata  : a_rdata;
    assign o_baddr  = r_sel ? b_baddr  : a_baddr;
    assign o_bwdata = r_sel ? b_bwdata : a_bwdata;
    assign o_be     = r_sel ? b_be     : a_be;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [1:0] mode, input logic [1:0] lane);
        if (mode == 2'b00) begin
            case (lane)
                2'd0: return 4'h1;
                2'd1: return 4'h2;
                2'd2: return 4'h4;
                default: return 4'h8;
            endcase
        end else if (mode == 2'b01) begin
            return lane[1] ? 4'hC : 4'h3;
        end
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] mode, input logic [31:0] wd);
        if (mode == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (mode == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] mode, input logic [1:0] lane,
                                            input logic uns, input logic [31:0] w);
        logic [31:0] v;
        if (mode == 2'b00) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (mode == 2'b01) begin
            v = (w >> (16 * lane[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // One legal transaction; ack_k = cycle of ack (0 = never).
    task automatic txn(input logic t_rd, input logic t_wr, input logic [1:0] t_mode,
                       input logic t_uns, input logic [31:0] t_addr, input logic [31:0] t_wd,
                       input int ack_k, input logic [31:0] t_brd, input string name);
        exp_t e, g;
        int   to, req_n, done_c;
        bit   done;
        to           = r_sel ? 4 : 255;
        e.addr       = {t_addr[31:2], 2'b00};
        e.be         = m_be(t_mode, t_addr[1:0]);
        e.we         = t_wr;
        e.wdata      = m_wdata(t_mode, t_wd);
        e.err        = (ack_k == 0) || (ack_k > to);
        e.rdata      = (t_wr || e.err) ? 32'd0 : m_rdata(t_mode, t_addr[1:0], t_uns, t_brd);
        e.req_cycles = e.err ? to : ack_k;
        @(negedge clk);
        r_rd = t_rd; r_wr = t_wr; r_mode = t_mode; r_uns = t_uns;
        r_addr = t_addr; r_wd = t_wd;
        sb.push_back(e);
        #1;
        n_checks++;
        if (o_stall !== 1'b1 || o_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_cycle0: stall=%b misalign=%b, required stall=1 misalign=0", name, o_stall, o_mis);
        end
        req_n = 0; done = 0; done_c = 0;
        for (int c = 1; c <= c_BOUND && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin r_rd = 1'b0; r_wr = 1'b0; end
            r_ack = (c == ack_k);
            r_brd = (c == ack_k) ? t_brd : $urandom;
            #1;
            if (o_stall) begin
                if (o_req) req_n++;
                if (c == 1) begin
                    n_checks++;
                    if (o_baddr !== e.addr || o_be !== e.be || o_we !== e.we || o_bwdata !== e.wdata) begin
                        n_fail++;
                        $display("FAIL %s_fields: addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                                 name, o_baddr, o_be, o_we, o_bwdata, e.addr, e.be, e.we, e.wdata);
                    end
                end
            end else begin
                done = 1; done_c = c;
            end
        end
        r_ack = 1'b0;
        n_checks++;
        if (!done || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_done: DONE not reached within %0d cycles", name, c_BOUND);
        end else begin
            g = sb.pop_front();
            if (o_rdata !== g.rdata || o_berr !== g.err || o_req !== 1'b0 ||
                req_n != g.req_cycles || done_c != g.req_cycles + 1) begin
                n_fail++;
                $display("FAIL %s_done: rdata=%h err=%b req=%b req_cycles=%0d done_cycle=%0d, required rdata=%h err=%b req=0 req_cycles=%0d done_cycle=%0d",
                         name, o_rdata, o_berr, o_req, req_n, done_c, g.rdata, g.err, g.req_cycles, g.req_cycles + 1);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (o_stall !== 1'b0 || o_berr !== 1'b0 || o_rdata !== 32'd0 || o_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: stall=%b err=%b rdata=%h req=%b, required all 0", name, o_stall, o_berr, o_rdata, o_req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({a_stall, a_mis, a_berr, a_req, a_we, a_be, a_rdata, a_baddr, a_bwdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b mis=%b err=%b req=%b we=%b be=%b rdata=%h addr=%h wdata=%h, required all 0",
                     a_stall, a_mis, a_berr, a_req, a_we, a_be, a_rdata, a_baddr, a_bwdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_word;
        txn(0, 1, 2'b10, 0, 32'h0000_0104, 32'hDEAD_BEEF, 1, 32'h0, "sw");
    endtask

    task automatic test_load_byte;
        txn(1, 0, 2'b00, 0, 32'h0000_1003, 32'hDEAD_BEEF, 0, 32'h0, "dummy_guard") ;
    endtask

    task automatic test_byte_loads;
        txn(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 4, 32'h80FF_0000, "lb");
        txn(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 4, 32'h80FF_0000, "lbu");
        txn(1, 0, 2'b00, 0, 32'h0000_1001, 32'h0, 2, 32'h1234_7F56, "lb_pos");
        txn(0, 1, 2'b00, 0, 32'h0000_1002, 32'h0000_00A5, 1, 32'h0, "sb");
    endtask

    task automatic test_half;
        txn(1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 2, 32'h8001_1234, "lh");
        txn(1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 2, 32'h8001_1234, "lhu");
        txn(1, 0, 2'b01, 0, 32'h0000_2000, 32'h0, 1, 32'h1234_8765, "lh_lo");
        txn(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h0, "sh");
    endtask

    task automatic illegal(input logic t_rd, input logic t_wr, input logic [1:0] t_mode,
                           input logic [31:0] t_addr, input string name);
        @(negedge clk);
        r_rd = t_rd; r_wr = t_wr; r_mode = t_mode; r_addr = t_addr; r_uns = 1'b0;
        #1;
        n_checks++;
        if (o_mis !== 1'b1 || o_stall !== 1'b0 || o_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: misalign=%b stall=%b req=%b, required 1 0 0", name, o_mis, o_stall, o_req);
        end
        @(negedge clk);
        r_rd = 1'b0; r_wr = 1'b0;
        #1;
        n_checks++;
        if (o_mis !== 1'b0 || o_stall !== 1'b0 || o_req !== 1'b0 || o_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL %s_after: misalign=%b stall=%b req=%b rdata=%h, required all 0", name, o_mis, o_stall, o_req, o_rdata);
        end
    endtask

    task automatic test_misalign;
        illegal(1, 0, 2'b10, 32'h0000_0006, "lw_mis");
        illegal(0, 1, 2'b01, 32'h0000_0001, "sh_mis");
        illegal(1, 0, 2'b11, 32'h0000_0000, "mode11");
        illegal(1, 1, 2'b10, 32'h0000_0100, "rd_and_wr");
    endtask

    task automatic test_timeout;
        r_sel = 1'b1;
        txn(1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 0, 32'h0, "lw_timeout");
        txn(1, 0, 2'b10, 0, 32'h0000_0304, 32'h0, 4, 32'hCAFE_F00D, "ack_at_expiry");
        txn(0, 1, 2'b00, 0, 32'h0000_0305, 32'h0000_0011, 0, 32'h0, "sb_timeout");
        txn(1, 0, 2'b10, 0, 32'h0000_0308, 32'h0, 3, 32'h1357_9BDF, "ack_before_expiry");
        r_sel = 1'b0;
    endtask

    task automatic test_reset_mid_req;
        @(negedge clk);
        r_rd = 1'b1; r_wr = 1'b0; r_mode = 2'b10; r_addr = 32'h0000_0400; r_uns = 1'b0;
        @(negedge clk);
        r_rd = 1'b0;
        #1;
        n_checks++;
        if (o_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: req=%b, required 1", o_req);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_req !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: req=%b stall=%b, required 0 0", o_req, o_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r_ack = 1'b1; r_brd = 32'h5555_AAAA;
        @(negedge clk);
        r_ack = 1'b0;
        #1;
        n_checks++;
        if (o_stall !== 1'b0 || o_rdata !== 32'd0 || o_req !== 1'b0 || o_berr !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack: stall=%b rdata=%h req=%b err=%b, required all 0", o_stall, o_rdata, o_req, o_berr);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  m;
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            m = 2'($urandom_range(0, 2));
            a = $urandom & 32'h0000_FFFF;
            if (m == 2'b01) a[0] = 1'b0;
            if (m == 2'b10) a[1:0] = 2'b00;
            txn(1, 0, m, 1'($urandom_range(0, 1)), a, 32'h0, $urandom_range(1, 3), $urandom, "b2b_ld");
            txn(0, 1, m, 0, a, $urandom, 1, 32'h0, "b2b_st");
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        r_sel = 1'b0; r_rd = 1'b0; r_wr = 1'b0; r_uns = 1'b0; r_ack = 1'b0;
        r_mode = 2'b00; r_addr = 32'd0; r_wd = 32'd0; r_brd = 32'd0;
        test_reset();
        test_store_word();
        test_byte_loads();
        test_half();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
